// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared types and constants for the post-decode pipeline controller.
//   stage_ctrl_t : per-stage control record (valid / writes-register / is-load).
//                  The wide per-stage fields (payload, dst, src, src_used) are
//                  sized by module parameters, so they live in parallel arrays
//                  next to this record inside pipe_ctrl.
//   FWD_NONE     : fwd_sel code meaning "use the register-file value". Any
//                  other code k names the stage k that supplies the operand.
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

  localparam int FWD_NONE = 0;

  typedef struct packed {
    logic valid;
    logic wr;
    logic load;
  } stage_ctrl_t;

endpackage

// File: rtl/pipe_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_if
// Bundles the issue handshake, redirect/freeze requests, forwarding selects,
// retirement outputs and statistics of pipe_ctrl.
//   master : the decode/issue side and observers (drives in_*, flush/freeze).
//   slave  : pipe_ctrl itself.
// Signal widths follow the same parameters as pipe_ctrl.
// -----------------------------------------------------------------------------
interface pipe_ctrl_if #(
  parameter int STAGES = 3,
  parameter int PW     = 64,
  parameter int AW     = 3,
  parameter int NSRC   = 2,
  parameter int FRZ_W  = 4,
  parameter int CNT_W  = 16
);
  localparam int SW = $clog2(STAGES);

  logic                 in_valid;
  logic                 in_ready;
  logic [PW-1:0]        in_payload;
  logic [AW-1:0]        in_dst;
  logic                 in_wr;
  logic                 in_load;
  logic [NSRC*AW-1:0]   in_src;
  logic [NSRC-1:0]      in_src_used;
  logic                 flush_req;
  logic                 freeze_req;
  logic [FRZ_W-1:0]     freeze_len;
  logic [NSRC*SW-1:0]   fwd_sel;
  logic [STAGES-1:0]    stage_valid;
  logic                 out_valid;
  logic [PW-1:0]        out_payload;
  logic [AW-1:0]        out_dst;
  logic                 out_wr;
  logic [CNT_W-1:0]     stall_cnt;
  logic [CNT_W-1:0]     flush_cnt;

  modport master (
    output in_valid, in_payload, in_dst, in_wr, in_load, in_src, in_src_used,
    output flush_req, freeze_req, freeze_len,
    input  in_ready, fwd_sel, stage_valid,
    input  out_valid, out_payload, out_dst, out_wr, stall_cnt, flush_cnt
  );

  modport slave (
    input  in_valid, in_payload, in_dst, in_wr, in_load, in_src, in_src_used,
    input  flush_req, freeze_req, freeze_len,
    output in_ready, fwd_sel, stage_valid,
    output out_valid, out_payload, out_dst, out_wr, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_fwd_select.sv
// -----------------------------------------------------------------------------
// pipe_fwd_select
// Chooses the forwarding source for one stage-0 source operand.
//   i_src      : stage-0 source register of this operand
//   i_used     : stage-0 stored "operand is read" bit
//   i_s0_valid : stage 0 holds a real instruction
//   i_valid    : valid bits of stages 1..STAGES-1
//   i_wr       : write-enable bits of stages 1..STAGES-1
//   i_load1    : stage 1 is a load (its data is not ready yet)
//   i_dst      : destination registers of stages 1..STAGES-1
//   o_sel      : youngest producing stage k, or FWD_NONE
// -----------------------------------------------------------------------------
module pipe_fwd_select
  import pipe_ctrl_pkg::*;
#(
  parameter int STAGES = 3,
  parameter int AW     = 3,
  localparam int SW    = $clog2(STAGES)
) (
  input  logic [AW-1:0]          i_src,
  input  logic                   i_used,
  input  logic                   i_s0_valid,
  input  logic [STAGES-1:1]      i_valid,
  input  logic [STAGES-1:1]      i_wr,
  input  logic                   i_load1,
  input  logic [STAGES*AW-1:AW]  i_dst,
  output logic [SW-1:0]          o_sel
);

  always_comb begin
    o_sel = SW'(FWD_NONE);
    if (i_s0_valid && i_used) begin
      // Scan oldest to youngest so the youngest (lowest k) producer wins.
      for (int k = STAGES - 1; k >= 1; k--) begin
        if (i_valid[k] && i_wr[k] && (i_dst[k*AW +: AW] == i_src) &&
            !(k == 1 && i_load1)) begin
          o_sel = SW'(k);
        end
      end
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl
// Post-decode in-order pipeline controller: STAGES entries from ID/EX
// (stage 0) to MEM/WB (last stage), with load-use stall, redirect flush,
// multi-cycle freeze, per-operand forwarding selects and statistics.
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : pipe_ctrl_if.slave (issue handshake, flush/freeze requests,
//          fwd_sel, stage_valid, retirement outputs, stall/flush counters)
// Priority each cycle: rst > frozen > flush (new or pending) > load-use > advance.
// -----------------------------------------------------------------------------
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int STAGES = 3,
  parameter int PW     = 64,
  parameter int AW     = 3,
  parameter int NSRC   = 2,
  parameter int FRZ_W  = 4,
  parameter int CNT_W  = 16
) (
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.slave  bus
);

  localparam int SW = $clog2(STAGES);

  stage_ctrl_t         r_ctrl     [STAGES];
  logic [PW-1:0]       r_payload  [STAGES];
  logic [AW-1:0]       r_dst      [STAGES];
  logic [NSRC*AW-1:0]  r_src      [STAGES];
  logic [NSRC-1:0]     r_src_used [STAGES];

  logic [FRZ_W-1:0]    r_frz_cnt;
  logic                r_flush_pend;
  logic [CNT_W-1:0]    r_stall_cnt;
  logic [CNT_W-1:0]    r_flush_cnt;

  logic                w_frozen;
  logic                w_src_hit;
  logic                w_hazard;
  logic                w_flush;
  logic                w_stall;
  logic                w_accept;
  stage_ctrl_t         w_s0_next;

  assign w_frozen = (r_frz_cnt != '0);

  // Does any read operand of the incoming instruction name stage 0's target?
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would infer a latch.
    w_src_hit = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (bus.in_src_used[i] && (bus.in_src[i*AW +: AW] == r_dst[0])) begin
        w_src_hit = 1'b1;
      end
    end
  end

  assign w_hazard = bus.in_valid && r_ctrl[0].valid && r_ctrl[0].wr &&
                    r_ctrl[0].load && w_src_hit;
  assign w_flush  = !w_frozen && (bus.flush_req || r_flush_pend);
  assign w_stall  = !w_frozen && !w_flush && w_hazard;
  assign w_accept = bus.in_valid && !w_frozen && !w_flush && !w_stall;

  // A flush still reports ready so the redirected instruction is consumed
  // (and dropped) instead of lingering on the bus.
  assign bus.in_ready = !rst && !w_frozen && !w_stall;

  always_comb begin
    w_s0_next = '0;
    if (w_accept) begin
      w_s0_next.valid = 1'b1;
      w_s0_next.wr    = bus.in_wr;
      w_s0_next.load  = bus.in_load;
    end
  end

  // Control state: valid bits, freeze counter, pending flush, statistics.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      for (int k = 0; k < STAGES; k++) r_ctrl[k] <= '0;
      r_frz_cnt    <= '0;
      r_flush_pend <= 1'b0;
      r_stall_cnt  <= '0;
      r_flush_cnt  <= '0;
    end else if (w_frozen) begin
      r_frz_cnt <= r_frz_cnt - FRZ_W'(1);
      if (bus.flush_req) r_flush_pend <= 1'b1;
    end else begin
      if (bus.freeze_req && (bus.freeze_len != '0)) r_frz_cnt <= bus.freeze_len;
      r_ctrl[0] <= w_s0_next;
      for (int k = 1; k < STAGES; k++) r_ctrl[k] <= r_ctrl[k-1];
      if (w_flush) begin
        r_flush_pend <= 1'b0;
        if (r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
      if (w_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  // NOTE: the per-stage data arrays carry no reset; they are only observed
  // through a stage whose valid bit is set, and that bit is reset above.
  always_ff @(posedge clk) begin
    if (!w_frozen) begin
      r_payload[0]  <= bus.in_payload;
      r_dst[0]      <= bus.in_dst;
      r_src[0]      <= bus.in_src;
      r_src_used[0] <= bus.in_src_used;
      for (int k = 1; k < STAGES; k++) begin
        r_payload[k]  <= r_payload[k-1];
        r_dst[k]      <= r_dst[k-1];
        r_src[k]      <= r_src[k-1];
        r_src_used[k] <= r_src_used[k-1];
      end
    end
  end

  // Forwarding inputs: stages 1..STAGES-1 only.
  logic [STAGES-1:1]     w_fwd_valid;
  logic [STAGES-1:1]     w_fwd_wr;
  logic [STAGES*AW-1:AW] w_fwd_dst;

  always_comb begin
    w_fwd_valid = '0;
    w_fwd_wr    = '0;
    w_fwd_dst   = '0;
    for (int k = 1; k < STAGES; k++) begin
      w_fwd_valid[k]         = r_ctrl[k].valid;
      w_fwd_wr[k]            = r_ctrl[k].wr;
      w_fwd_dst[k*AW +: AW]  = r_dst[k];
    end
  end

  for (genvar i = 0; i < NSRC; i++) begin : g_fwd
    logic [SW-1:0] w_sel;

    pipe_fwd_select #(.STAGES(STAGES), .AW(AW)) u_fwd_select (
      .i_src      (r_src[0][i*AW +: AW]),
      .i_used     (r_src_used[0][i]),
      .i_s0_valid (r_ctrl[0].valid),
      .i_valid    (w_fwd_valid),
      .i_wr       (w_fwd_wr),
      .i_load1    (r_ctrl[1].load),
      .i_dst      (w_fwd_dst),
      .o_sel      (w_sel)
    );

    assign bus.fwd_sel[i*SW +: SW] = rst ? SW'(FWD_NONE) : w_sel;
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage_valid
    assign bus.stage_valid[k] = r_ctrl[k].valid;
  end

  // While frozen the last stage holds, so suppress out_valid to present each
  // entry exactly once (on the cycle it actually leaves).
  assign bus.out_valid   = !rst && !w_frozen && r_ctrl[STAGES-1].valid;
  assign bus.out_payload = r_payload[STAGES-1];
  assign bus.out_dst     = r_dst[STAGES-1];
  assign bus.out_wr      = r_ctrl[STAGES-1].wr;
  assign bus.stall_cnt   = r_stall_cnt;
  assign bus.flush_cnt   = r_flush_cnt;

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter STAGES, default 3, number of post-decode pipeline stages (stage 0 = ID/EX, last stage = MEM/WB); legal range 3..8.
REQ-002 Parameter PW, default 64, payload width carried per entry.
REQ-003 Parameter AW, default 3, register-address width.
REQ-004 Parameter NSRC, default 2, source operands per instruction.
REQ-005 Parameter FRZ_W, default 4, freeze-length width; parameter CNT_W, default 16, statistics-counter width.
REQ-006 Ports, in order:
- clk  in  1  only clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  decoded instruction present.
- in_ready  out  1  instruction accepted when in_valid && in_ready.
- in_payload  in  PW  opaque decoded fields.
- in_dst  in  AW  destination register.
- in_wr  in  1  writes a register.
- in_load  in  1  is a memory load.
- in_src  in  NSRC*AW  source registers, operand i at [i*AW +: AW].
- in_src_used  in  NSRC  operand i is read.
- flush_req  in  1  branch/call/ret redirect; kill younger work.
- freeze_req  in  1  request a multi-cycle freeze.
- freeze_len  in  FRZ_W  freeze length in cycles.
- fwd_sel  out  NSRC*$clog2(STAGES)  per-operand forwarding source for stage 0.
- stage_valid  out  STAGES  valid bit of each stage.
- out_valid  out  1  retiring entry present.
- out_payload  out  PW  last-stage payload.
- out_dst  out  AW  last-stage destination.
- out_wr  out  1  last-stage write enable.
- stall_cnt  out  CNT_W  load-use stall cycles.
- flush_cnt  out  CNT_W  applied flushes.

Function
REQ-007 Each stage SHALL hold valid, payload, dst, wr, load, and src fields; on advance, stage k SHALL load stage k-1 and stage 0 SHALL load the accepted input, or a bubble (valid=0) when nothing is accepted.
REQ-008 frozen SHALL be registered and equal (frz_cnt != 0).
REQ-009 freeze_req with freeze_len != 0 while not frozen SHALL load frz_cnt = freeze_len, so the freeze takes effect next cycle and lasts exactly freeze_len cycles.
REQ-010 freeze_len == 0, and freeze_req while frozen, SHALL be ignored.
REQ-011 While frozen, all stages SHALL hold, in_ready = 0, out_valid = 0, and frz_cnt SHALL decrement by 1 per cycle.
REQ-012 Load-use hazard SHALL be declared when: stage 0 is valid with wr = 1 and load = 1; and some operand i of the input has in_src_used[i] = 1 and a source equal to stage-0 dst; and in_valid = 1.
REQ-013 On a load-use hazard, in_ready SHALL be 0, stage 0 SHALL take a bubble, and older stages SHALL advance (one-cycle stall per hazard).
REQ-014 On flush_req when not frozen, in_ready SHALL be 1, the input SHALL be discarded, stage 0 SHALL take a bubble, and older stages SHALL advance.
REQ-015 flush_req while frozen SHALL set a pending flag, which SHALL be applied as a flush on the first unfrozen cycle and then cleared.
REQ-016 Priority SHALL be rst > frozen > flush (requested or pending) > load-use > normal advance.
REQ-017 fwd_sel for operand i SHALL be k (1 ≤ k < STAGES) for the lowest k whose stage is valid, has wr = 1, has dst equal to stage-0 src i, and is not (k == 1 && load == 1); otherwise fwd_sel SHALL be 0.
REQ-018 fwd_sel SHALL be 0 for any operand whose stored src_used bit is 0, and for all operands when stage 0 is invalid.
REQ-019 fwd_sel SHALL be combinational from registered state.
REQ-020 out_* SHALL reflect the last stage, with out_valid = last.valid && !frozen, so each entry is presented exactly once.
REQ-021 stall_cnt SHALL increment on each load-use stall cycle, and flush_cnt on each applied flush; both SHALL saturate at all-ones.
REQ-022 Register r0 SHALL be treated as a normal register (no zero-register exemption).

Reset
REQ-023 On rst, all stage valid bits, frz_cnt, the pending-flush flag, stall_cnt, and flush_cnt SHALL clear to 0.
REQ-024 During reset, in_ready = 0, out_valid = 0, and fwd_sel = 0; stage payloads need not be cleared.
REQ-025 Reset asserted mid-freeze or mid-stall SHALL abort it; the first post-reset cycle SHALL be normal with in_ready = 1.

Structure
REQ-026 Package pipe_ctrl_pkg SHALL hold the stage-record struct and the fwd_sel encoding constants (FWD_NONE = 0).
REQ-027 Forward-source selection for one operand SHALL be the sub-module pipe_fwd_select, instantiated NSRC times.

Verification
REQ-028 Scenario, streaming: 10 back-to-back independent instructions, no hazards -> in_ready stays 1; each retires with out_valid exactly STAGES cycles after acceptance, in order, payloads intact.
REQ-029 Scenario, load-use: load r3 followed by an instruction with src0 = r3 -> one-cycle in_ready = 0, a bubble in stage 0, stall_cnt = 1; on issue, fwd_sel[0] = 2.
REQ-030 Scenario, ALU-to-ALU: add writing r5 then an instruction reading r5 -> no stall, fwd_sel = 1; with one independent instruction between them, fwd_sel = 2.
REQ-031 Scenario, flush with hazard: flush_req in the same cycle as a load-use hazard -> input dropped, in_ready = 1, flush_cnt = 1, stall_cnt unchanged.
REQ-032 Scenario, freeze with flush: freeze_req with freeze_len = 3, then flush_req during the freeze -> out_valid = 0 and all stages hold for 3 cycles; the flush is applied in cycle 4 and no entry is lost or duplicated at the output.
REQ-033 Scenario, reset mid-operation: rst asserted during freeze_len = 5 at count 2 -> next cycle stage_valid = 0 and counters = 0; after release in_ready = 1.
